apb_slave_responder: RTL
========================

Name: apb_slave_responder

Overview:
Synthesizable APB4 completer (slave) that answers transfers issued by the master agent. It decodes one select line and holds a byte-strobed word memory. It inserts a run-time programmable number of wait states and flags PSLVERR on illegal accesses. It is the DUT-side counterpart that the master driver and the slave monitor exercise.

Parameters:
- ADDRESS_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- MEM_DEPTH, 64, number of DATA_WIDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- pclk  input  1  APB clock; all state updates on the rising edge.
- preset_n  input  1  asynchronous, active-low reset.
- pselx  input  1  select for this slave.
- penable  input  1  access phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDRESS_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- pprot  input  3  protection type.
- wait_states  input  4  number of wait cycles to insert per transfer; sampled in the setup phase.
- pready  output  1  transfer completion.
- prdata  output  DATA_WIDTH  read data.
- pslverr  output  1  error response.

Behaviour:
- Reset (preset_n low, asynchronous):
  - state = IDLE.
  - pready = 0, prdata = 0, pslverr = 0.
  - Wait counter = 0.
  - All memory words = 0.
  - A reset asserted mid-transfer aborts the transfer. No write is committed.
- States: IDLE, ACCESS.
- IDLE:
  - On an edge with pselx=1 and penable=0 (setup phase), capture paddr, pwrite, pwdata, pstrb and pprot.
  - Load cnt = wait_states and set pready <= (wait_states==0).
  - Go to ACCESS.
- ACCESS, on each edge with pselx=1 and penable=1:
  - If pready=1: the transfer completes at this edge. Set pready <= 0, pslverr <= 0 and go to IDLE.
  - Otherwise: cnt <= cnt-1 and pready <= (cnt==1).
- Wait-state count: N wait states means exactly N access cycles with pready low before the cycle with pready high. Zero wait states gives pready high in the first access cycle.
- Response data: prdata and pslverr are updated on the same edge that raises pready. Both hold while pready=1. pslverr is 0 whenever pready=0.
- prdata on an error read or on a write = 0.
- Error decode. Any one of the following sets pslverr=1:
  - paddr < BASE_ADDR;
  - word index (paddr-BASE_ADDR)>>log2(DATA_WIDTH/8) >= MEM_DEPTH;
  - paddr not aligned to DATA_WIDTH/8.
- Writes:
  - Committed at the completion edge only, and only when there is no error.
  - Byte lane i is updated iff pstrb[i]=1. pstrb=0 on a write means no change and no error.
  - An errored write leaves the memory unchanged.
- Reads:
  - pstrb is ignored.
  - A read issued after a completed write to the same word returns the new data.
- Protocol violations:
  - pselx dropped while in ACCESS: abort to IDLE, pready=0, no write.
  - penable=1 seen in IDLE: ignored.
- Back-to-back transfers: a new setup on the cycle immediately after completion is accepted with no bubble.

Optional Feature:
- Macro: APB_SLAVE_PPROT_CHECK_EN.
- Defined: a non-secure access (pprot[1]=1) to the upper half of memory (word index >= MEM_DEPTH/2) completes with pslverr=1. A write in that case is not committed.
- Undefined: pprot is captured but ignored, and no protection errors are generated.

Decomposition:
- Shared package (apb_global_pkg) holds slave_error_e, tx_type_e and protection_type_e.
- New entry in the same package: apb_slave_state_e {IDLE, ACCESS}.
- One sub-module: apb_slave_mem. It is a MEM_DEPTH x DATA_WIDTH array with a byte-strobed write port, a combinational read port and asynchronous clear. The responder contains the FSM, the wait counter and the error decode.

Test Plan:
- Zero wait, write then read:
  - Write 0xDEADBEEF to 0x10 with pstrb=4'hF, wait_states=0. pready is high in the first access cycle and pslverr=0.
  - Read 0x10. prdata=0xDEADBEEF.
- Wait states: wait_states=3, read 0x0. pready is low for exactly 3 access cycles, then high for 1 cycle, with prdata=0.
- Partial strobe:
  - Write 0x11223344 with pstrb=4'hF to 0x4.
  - Then write 0xAABBCCDD with pstrb=4'b0101.
  - Read 0x4 returns 0x11BB33DD.
- Errors:
  - Read 0x100 (word 64) gives pslverr=1 and prdata=0.
  - Write to 0x2 (unaligned) gives pslverr=1, and memory at 0x0 is unchanged.
- Abort and reset:
  - wait_states=5 write to 0x8. Drop pselx after 2 access cycles. Read 0x8 returns the old value.
  - Separately, pulse preset_n low mid-access. pready, pslverr and prdata go to 0 immediately, and a read of 0x8 returns 0.
- With APB_SLAVE_PPROT_CHECK_EN defined:
  - pprot=3'b010 write to 0x80 (word 32) gives pslverr=1.
  - Same access with pprot=3'b000 gives pslverr=0.

Source files
------------

// File: rtl/apb_global_pkg.sv
// Types shared by the APB agents and the slave responder.
package apb_global_pkg;

  typedef enum logic {
    SLV_OKAY  = 1'b0,
    SLV_ERROR = 1'b1
  } slave_error_e;

  typedef enum logic {
    TX_READ  = 1'b0,
    TX_WRITE = 1'b1
  } tx_type_e;

  // One-hot pprot attribute bits: [0] privileged, [1] non-secure, [2] instruction.
  typedef enum logic [2:0] {
    PROT_NORMAL    = 3'b000,
    PROT_PRIV      = 3'b001,
    PROT_NONSECURE = 3'b010,
    PROT_INSTR     = 3'b100
  } protection_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_responder_if.sv
// APB4 bus bundle between a requester and a completer.
interface apb_slave_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                      pselx;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// Word memory with byte-strobed write, combinational read and asynchronous clear.
module apb_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_slave_responder.sv
// APB4 completer: wait-state FSM, address/protection error decode, word memory.
// Define APB_SLAVE_PPROT_CHECK_EN to reject non-secure accesses to the upper half of memory.
module apb_slave_responder
  import apb_global_pkg::*;
#(
  parameter int unsigned             ADDRESS_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH    = 32,
  parameter int unsigned             MEM_DEPTH     = 64,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [3:0]           wait_states,
  apb_slave_responder_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);

  apb_slave_state_e          state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  tx_type_e                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;

  logic                      setup;
  logic [ADDRESS_WIDTH-1:0]  addr_sel, offset, word;
  logic                      write_sel, nonsecure_sel, addr_err, prot_err, err;
  slave_error_e              resp;
  logic [DATA_WIDTH-1:0]     mem_rdata, rsp_data;
  logic                      mem_we;
  logic                      unused_prot;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      addr_q    <= '0;
      tx_q      <= TX_READ;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
    end
  end

  // The response may be produced on the setup edge itself, so decode the live bus in IDLE.
  assign setup         = bus.pselx && !bus.penable;
  assign addr_sel      = (state_q == IDLE) ? bus.paddr : addr_q;
  assign write_sel     = (state_q == IDLE) ? bus.pwrite : (tx_q == TX_WRITE);
  assign nonsecure_sel = (state_q == IDLE) ? bus.pprot[1] : prot_q[1];
  assign offset        = addr_sel - BASE_ADDR;
  assign word          = offset >> ADDR_LSB;
  assign addr_err      = (addr_sel < BASE_ADDR) || (word >= ADDRESS_WIDTH'(MEM_DEPTH)) ||
                         ((addr_sel & ADDRESS_WIDTH'(STRB_WIDTH - 1)) != '0);
`ifdef APB_SLAVE_PPROT_CHECK_EN
  assign prot_err      = nonsecure_sel && (word >= ADDRESS_WIDTH'(MEM_DEPTH / 2));
`else
  assign prot_err      = 1'b0 & nonsecure_sel;
`endif
  assign err           = addr_err || prot_err;
  assign resp          = err ? SLV_ERROR : SLV_OKAY;
  assign rsp_data      = (write_sel || err) ? '0 : mem_rdata;
  assign unused_prot   = ^prot_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (setup) state_d = ACCESS;
      ACCESS: begin
        if (!bus.pselx) state_d = IDLE;
        else if (bus.penable && pready_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d   = bus.paddr;
          tx_d     = bus.pwrite ? TX_WRITE : TX_READ;
          wdata_d  = bus.pwdata;
          strb_d   = bus.pstrb;
          prot_d   = bus.pprot;
          cnt_d    = wait_states;
          pready_d = (wait_states == 4'd0);
          if (wait_states == 4'd0) begin
            prdata_d  = rsp_data;
            pslverr_d = (resp == SLV_ERROR);
          end
        end
      end
      ACCESS: begin
        if (!bus.pselx) begin
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (bus.penable) begin
          if (pready_q) begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            mem_we    = (tx_q == TX_WRITE) && !err;
          end else begin
            cnt_d    = cnt_q - 4'd1;
            pready_d = (cnt_q == 4'd1);
            if (cnt_q == 4'd1) begin
              prdata_d  = rsp_data;
              pslverr_d = (resp == SLV_ERROR);
            end
          end
        end
      end
      default: ;
    endcase
  end

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .rst_n (preset_n),
    .we    (mem_we),
    .addr  (word[IDX_W-1:0]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .rdata (mem_rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule
